// File: rtl/weight_sched_pkg.sv
// Shared types and constants for the weight fetch scheduler.
package weight_sched_pkg;

  localparam int DEF_DATA_LEN  = 64;
  localparam int DEF_NUM_LANES = 4;
  localparam int DEF_BURST_LEN = 16;

  typedef enum logic [1:0] {
    ARB    = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  // Ceiling log2; returns 0 for values <= 1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first requester
// at or after ptr, wrapping past the top lane. The pointer register lives
// in the caller.
module rr_arbiter
  import weight_sched_pkg::*;
#(
  parameter int NUM_LANES = DEF_NUM_LANES,
  localparam int PTR_W    = clog2(NUM_LANES)
) (
  input  logic [NUM_LANES-1:0] req,
  input  logic [PTR_W-1:0]     ptr,
  output logic [NUM_LANES-1:0] grant
);

  logic           found;
  int             idx_int;
  logic [PTR_W-1:0] idx;

  // Scan lanes starting at ptr and grant the first active request.
  always_comb begin
    grant   = '0;
    found   = 1'b0;
    idx_int = 0;
    idx     = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      idx_int = int'(ptr) + i;
      if (idx_int >= NUM_LANES) idx_int = idx_int - NUM_LANES;
      idx = PTR_W'(idx_int);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/weight_fetch_scheduler.sv
// Weight fetch scheduler: shares one show-ahead weight FIFO among the PE
// lanes, granting one lane at a time round-robin and streaming exactly
// BURST_LEN words per grant through a 1-deep output register.
// Optional build macro WFS_STALL_CNT_EN adds stall_cnt, a saturating count
// of STREAM cycles in which the FIFO starved an otherwise ready datapath.
module weight_fetch_scheduler
  import weight_sched_pkg::*;
#(
  parameter int DATA_LEN  = DEF_DATA_LEN,
  parameter int NUM_LANES = DEF_NUM_LANES,
  parameter int BURST_LEN = DEF_BURST_LEN
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_LEN-1:0]  fifo_data,
  input  logic                 fifo_empty,
  output logic                 fifo_req,
  input  logic [NUM_LANES-1:0] lane_req,
  input  logic [NUM_LANES-1:0] lane_ready,
  output logic [NUM_LANES-1:0] lane_grant,
  output logic [DATA_LEN-1:0]  wt_data,
  output logic                 wt_valid,
  output logic                 wt_last,
  output logic                 busy
`ifdef WFS_STALL_CNT_EN
  ,
  output logic [31:0]          stall_cnt
`endif
);

  localparam int PTR_W = clog2(NUM_LANES);
  localparam int CNT_W = clog2(BURST_LEN + 1);

  state_t               state_q,   state_d;
  logic [PTR_W-1:0]     ptr_q,     ptr_d;
  logic [NUM_LANES-1:0] grant_q,   grant_d;
  logic [DATA_LEN-1:0]  data_q,    data_d;
  logic                 valid_q,   valid_d;
  logic                 last_q,    last_d;
  logic [CNT_W-1:0]     pop_cnt_q, pop_cnt_d;

  logic [NUM_LANES-1:0] arb_grant;
  logic [PTR_W-1:0]     g_idx;
  logic [PTR_W-1:0]     ptr_next;
  logic                 gnt_ready;
  logic                 xfer;
  logic                 last_pop;

  rr_arbiter #(
    .NUM_LANES (NUM_LANES)
  ) u_arb (
    .req   (lane_req),
    .ptr   (ptr_q),
    .grant (arb_grant)
  );

  assign gnt_ready = |(lane_ready & grant_q);
  assign xfer      = valid_q & gnt_ready;
  assign last_pop  = (pop_cnt_q == CNT_W'(BURST_LEN - 1));
  // A pop is only allowed when the output register is empty or emptying.
  assign fifo_req  = (state_q == STREAM) & ~fifo_empty & (~valid_q | gnt_ready);

  assign lane_grant = grant_q;
  assign wt_data    = data_q;
  assign wt_valid   = valid_q;
  assign wt_last    = last_q;
  assign busy       = (state_q != ARB);

  // Encode the owning lane and derive the pointer that follows it.
  always_comb begin
    g_idx = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (grant_q[i]) g_idx = PTR_W'(i);
    end
    ptr_next = (g_idx == PTR_W'(NUM_LANES - 1)) ? '0 : g_idx + PTR_W'(1);
  end

  // Next-state logic for arbitration, streaming and draining the last word.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    grant_d   = grant_q;
    data_d    = data_q;
    valid_d   = valid_q;
    last_d    = last_q;
    pop_cnt_d = pop_cnt_q;
    case (state_q)
      ARB: begin
        if (|lane_req) begin
          grant_d   = arb_grant;
          pop_cnt_d = '0;
          state_d   = STREAM;
        end
      end
      STREAM: begin
        if (fifo_req) begin
          data_d    = fifo_data;
          valid_d   = 1'b1;
          last_d    = last_pop;
          pop_cnt_d = pop_cnt_q + CNT_W'(1);
          if (last_pop) state_d = DRAIN;
        end else if (xfer) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
        end
      end
      DRAIN: begin
        if (xfer) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          grant_d = '0;
          ptr_d   = ptr_next;
          state_d = ARB;
        end
      end
      default: state_d = ARB;
    endcase
  end

  // FSM and registered outputs; reset aborts any burst in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ARB;
      ptr_q     <= '0;
      grant_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      pop_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      grant_q   <= grant_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      last_q    <= last_d;
      pop_cnt_q <= pop_cnt_d;
    end
  end

`ifdef WFS_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic        starve;

  assign starve    = (state_q == STREAM) & fifo_empty & (~valid_q | gnt_ready);
  assign stall_cnt = stall_cnt_q;

  // Saturating count of cycles the FIFO starved a burst.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (starve && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  // Starvation counter register.
  always_ff @(posedge clk) begin
    if (rst) stall_cnt_q <= '0;
    else     stall_cnt_q <= stall_cnt_d;
  end
`endif

endmodule
